// File: rtl/systolic_mm_engine_if.sv
// Operand stream, job control and result bus of systolic_mm_engine.
// master = operand/control source, slave = the engine.
interface systolic_mm_engine_if #(
  parameter int DWIDTH = 32,
  parameter int N      = 3,
  parameter int KMAX   = 16,
  parameter int ACCW   = 2*DWIDTH
);
  localparam int KW = $clog2(KMAX+1);

  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DWIDTH-1:0]   a_col;
  logic [N*DWIDTH-1:0]   b_row;
  logic                  busy;
  logic                  done;
  logic [N*N*ACCW-1:0]   results;

  modport master (
    output start, k_len, in_valid, a_col, b_row,
    input  in_ready, busy, done, results
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row,
    output in_ready, busy, done, results
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary NxN matrix-multiply engine (C = A*B, runtime K) with built-in input skew.
// Optional macro SYSTOLIC_SAT_EN: unsigned saturating accumulation instead of wrap-around.
module systolic_mm_engine #(
  parameter int DWIDTH = 32,
  parameter int N      = 3,
  parameter int KMAX   = 16,
  parameter int ACCW   = 2*DWIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  systolic_mm_engine_if.slave   mm
);
  localparam int KW  = $clog2(KMAX+1);
  localparam int DCW = $clog2(2*N-1);
  localparam int TRI = (N*(N-1))/2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [KW-1:0]       r_k_len, r_beat_cnt, w_k_clamp;
  logic [DCW-1:0]      r_drain_cnt;
  logic                w_start, w_accept, w_last_beat, w_drain_end;

  // Triangular skew storage: row/column i owns stages [i*(i-1)/2 .. i*(i-1)/2+i-1]
  logic [TRI*DWIDTH-1:0] r_a_skew, r_b_skew;
  logic [TRI-1:0]        r_a_skew_v, r_b_skew_v;

  logic [DWIDTH-1:0]   w_pe_a [N][N];
  logic [DWIDTH-1:0]   w_pe_b [N][N];
  logic                w_pe_a_v [N][N];
  logic                w_pe_b_v [N][N];
  logic [DWIDTH-1:0]   r_pe_a [N][N-1];
  logic                r_pe_a_v [N][N-1];
  logic [DWIDTH-1:0]   r_pe_b [N-1][N];
  logic                r_pe_b_v [N-1][N];
  logic [ACCW-1:0]     r_acc [N][N];
  logic [N*N*ACCW-1:0] w_results;

`ifdef SYSTOLIC_SAT_EN
  localparam int PW = 2*DWIDTH;
  localparam int WW = ((ACCW > PW) ? ACCW : PW) + 1;

  // The WW-bit sum cannot overflow, so one compare saturates both product and sum.
  function automatic logic [ACCW-1:0] f_mac(input logic [ACCW-1:0] acc,
                                            input logic [DWIDTH-1:0] a,
                                            input logic [DWIDTH-1:0] b);
    logic [PW-1:0] prod;
    logic [WW-1:0] sum;
    prod = PW'(a) * PW'(b);
    sum  = WW'(acc) + WW'(prod);
    if (sum > WW'({ACCW{1'b1}})) begin
      f_mac = {ACCW{1'b1}};
    end else begin
      f_mac = sum[ACCW-1:0];
    end
  endfunction
`else
  function automatic logic [ACCW-1:0] f_mac(input logic [ACCW-1:0] acc,
                                            input logic [DWIDTH-1:0] a,
                                            input logic [DWIDTH-1:0] b);
    f_mac = acc + (ACCW'(a) * ACCW'(b));
  endfunction
`endif

  assign w_start     = (r_state == ST_IDLE) && mm.start;
  assign w_accept    = (r_state == ST_LOAD) && mm.in_valid;
  assign w_k_clamp   = (mm.k_len > KW'(KMAX)) ? KW'(KMAX) : mm.k_len;
  assign w_last_beat = (r_beat_cnt == (r_k_len - KW'(1)));
  assign w_drain_end = (r_drain_cnt == DCW'(2*N-2));

  assign mm.in_ready = (r_state == ST_LOAD);
  assign mm.busy     = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign mm.done     = (r_state == ST_DONE);
  assign mm.results  = w_results;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mm.start) begin
          w_state_nxt = (mm.k_len == {KW{1'b0}}) ? ST_DONE : ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_accept && w_last_beat) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (w_drain_end) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Job length latch, beat counter and drain counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_k_len     <= {KW{1'b0}};
      r_beat_cnt  <= {KW{1'b0}};
      r_drain_cnt <= {DCW{1'b0}};
    end else if (w_start) begin
      r_k_len     <= w_k_clamp;
      r_beat_cnt  <= {KW{1'b0}};
      r_drain_cnt <= {DCW{1'b0}};
    end else begin
      if (w_accept) r_beat_cnt <= r_beat_cnt + KW'(1);
      if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + DCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_skew   <= {(TRI*DWIDTH){1'b0}};
      r_b_skew   <= {(TRI*DWIDTH){1'b0}};
      r_a_skew_v <= {TRI{1'b0}};
      r_b_skew_v <= {TRI{1'b0}};
    end else begin
      for (int i = 1; i < N; i++) begin
        for (int s = 0; s < i; s++) begin
          if (s == 0) begin
            r_a_skew[(i*(i-1)/2)*DWIDTH +: DWIDTH] <= mm.a_col[i*DWIDTH +: DWIDTH];
            r_b_skew[(i*(i-1)/2)*DWIDTH +: DWIDTH] <= mm.b_row[i*DWIDTH +: DWIDTH];
            r_a_skew_v[i*(i-1)/2] <= w_accept;
            r_b_skew_v[i*(i-1)/2] <= w_accept;
          end else begin
            r_a_skew[(i*(i-1)/2+s)*DWIDTH +: DWIDTH] <= r_a_skew[(i*(i-1)/2+s-1)*DWIDTH +: DWIDTH];
            r_b_skew[(i*(i-1)/2+s)*DWIDTH +: DWIDTH] <= r_b_skew[(i*(i-1)/2+s-1)*DWIDTH +: DWIDTH];
            r_a_skew_v[i*(i-1)/2+s] <= r_a_skew_v[i*(i-1)/2+s-1];
            r_b_skew_v[i*(i-1)/2+s] <= r_b_skew_v[i*(i-1)/2+s-1];
          end
        end
      end
    end
  end

  // Operand seen by each PE: skew-line output at the array edge, else the neighbour's register
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_pe_a[i][j]   = {DWIDTH{1'b0}};
        w_pe_b[i][j]   = {DWIDTH{1'b0}};
        w_pe_a_v[i][j] = 1'b0;
        w_pe_b_v[i][j] = 1'b0;
      end
    end
    w_pe_a[0][0]   = mm.a_col[DWIDTH-1:0];
    w_pe_a_v[0][0] = w_accept;
    w_pe_b[0][0]   = mm.b_row[DWIDTH-1:0];
    w_pe_b_v[0][0] = w_accept;
    for (int i = 1; i < N; i++) begin
      w_pe_a[i][0]   = r_a_skew[(i*(i-1)/2+i-1)*DWIDTH +: DWIDTH];
      w_pe_a_v[i][0] = r_a_skew_v[i*(i-1)/2+i-1];
      w_pe_b[0][i]   = r_b_skew[(i*(i-1)/2+i-1)*DWIDTH +: DWIDTH];
      w_pe_b_v[0][i] = r_b_skew_v[i*(i-1)/2+i-1];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 1; j < N; j++) begin
        w_pe_a[i][j]   = r_pe_a[i][j-1];
        w_pe_a_v[i][j] = r_pe_a_v[i][j-1];
        w_pe_b[j][i]   = r_pe_b[j-1][i];
        w_pe_b_v[j][i] = r_pe_b_v[j-1][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N-1; j++) begin
          r_pe_a[i][j]   <= {DWIDTH{1'b0}};
          r_pe_a_v[i][j] <= 1'b0;
          r_pe_b[j][i]   <= {DWIDTH{1'b0}};
          r_pe_b_v[j][i] <= 1'b0;
        end
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= {ACCW{1'b0}};
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N-1; j++) begin
          r_pe_a[i][j]   <= w_pe_a[i][j];
          r_pe_a_v[i][j] <= w_pe_a_v[i][j];
          r_pe_b[j][i]   <= w_pe_b[j][i];
          r_pe_b_v[j][i] <= w_pe_b_v[j][i];
        end
        for (int j = 0; j < N; j++) begin
          if (w_start) begin
            r_acc[i][j] <= {ACCW{1'b0}};
          end else if (w_pe_a_v[i][j] && w_pe_b_v[i][j]) begin
            r_acc[i][j] <= f_mac(r_acc[i][j], w_pe_a[i][j], w_pe_b[i][j]);
          end else begin
            r_acc[i][j] <= r_acc[i][j];
          end
        end
      end
    end
  end

  always_comb begin
    w_results = {(N*N*ACCW){1'b0}};
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_results[(i*N+j)*ACCW +: ACCW] = r_acc[i][j];
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine: directed and random jobs against a plain-arithmetic model.
module tb_systolic_mm_engine;
  localparam int DW = 8;
  localparam int NN = 3;
  localparam int KM = 16;
  localparam int AW = 16;
  localparam int KW = $clog2(KM+1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  systolic_mm_engine_if #(.DWIDTH(DW), .N(NN), .KMAX(KM), .ACCW(AW)) mm();

  systolic_mm_engine #(.DWIDTH(DW), .N(NN), .KMAX(KM), .ACCW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .mm   (mm)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned ma [NN][KM];
  int unsigned mb [KM][NN];
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain sum of products, then wrap or clamp to the accumulator range
  function automatic logic [NN*NN*AW-1:0] model(input int k);
    logic [NN*NN*AW-1:0] r;
    longint s;
    longint lim;
    r   = '0;
    lim = longint'(1) << AW;
    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NN; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(ma[i][kk]) * longint'(mb[kk][j]);
`ifdef SYSTOLIC_SAT_EN
        if (s > lim - 1) s = lim - 1;
`else
        s = s % lim;
`endif
        r[(i*NN+j)*AW +: AW] = s[AW-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [NN*DW-1:0] a_beat(input int k);
    logic [NN*DW-1:0] r;
    for (int i = 0; i < NN; i++) r[i*DW +: DW] = DW'(ma[i][k]);
    return r;
  endfunction

  function automatic logic [NN*DW-1:0] b_beat(input int k);
    logic [NN*DW-1:0] r;
    for (int j = 0; j < NN; j++) r[j*DW +: DW] = DW'(mb[k][j]);
    return r;
  endfunction

  task automatic fill_basic();
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < NN; k++) begin
        ma[i][k] = i*3 + k + 1;
        mb[k][i] = 10 + k*3 + i;
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < KM; k++) begin
        ma[i][k] = $urandom_range(0, 255);
        mb[k][i] = $urandom_range(0, 255);
      end
  endtask

  task automatic check_basic_consts(input string nm);
    int exp_c [9] = '{84, 90, 96, 201, 216, 231, 318, 342, 366};
    for (int e = 0; e < 9; e++)
      check_eq($sformatf("%s_c%0d", nm, e), mm.results[e*AW +: AW], exp_c[e]);
  endtask

  // mode 0: back-to-back, 1: fixed stall pattern, 2: random stalls
  task automatic run_job(input string nm, input int klen, input int mode, input bit poke);
    int keff, acc, cyc, lat, extra, pi;
    bit v, take;
    keff  = (klen > KM) ? KM : klen;
    acc   = 0; cyc = 0; pi = 0; extra = 0;
    mm.k_len    = KW'(klen);
    mm.start    = 1'b1;
    mm.in_valid = 1'b0;
    step();
    mm.start = 1'b0;
    if (keff == 0) begin
      check_eq({nm, "_done"}, mm.done, 1);
      check_eq({nm, "_busy"}, {mm.busy, mm.in_ready}, 0);
      check_eq({nm, "_res"}, mm.results, model(0));
      step();
      check_eq({nm, "_done_pulse"}, mm.done, 0);
      return;
    end
    check_eq({nm, "_busy_load"}, mm.busy, 1);
    while (acc < keff && cyc < 400) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = pat[pi % 6];
      else v = 1'($urandom_range(0, 1));
      pi++;
      mm.in_valid = v;
      mm.a_col    = a_beat(acc);
      mm.b_row    = b_beat(acc);
      if (poke && acc == 1) begin
        mm.start = 1'b1;
        mm.k_len = KW'(1);
      end
      take = v && mm.in_ready;
      step();
      mm.start = 1'b0;
      if (take) acc++;
      cyc++;
    end
    check_eq({nm, "_beats"}, acc, keff);
    mm.in_valid = 1'b1;
    lat = 0;
    while (!mm.done && lat < 20) begin
      if (mm.in_ready) extra++;
      step();
      lat++;
    end
    check_eq({nm, "_latency"}, lat, 2*NN-1);
    check_eq({nm, "_extra_beats"}, extra, 0);
    check_eq({nm, "_res"}, mm.results, model(keff));
    check_eq({nm, "_busy_done"}, mm.busy, 0);
    mm.in_valid = 1'b0;
    step();
    check_eq({nm, "_done_pulse"}, {mm.done, mm.busy}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mm.start = 1'b0; mm.k_len = '0; mm.in_valid = 1'b0; mm.a_col = '0; mm.b_row = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {mm.busy, mm.done, mm.in_ready}, 0);
    check_eq("rst_res", mm.results, 0);
    @(negedge clk) rstn = 1'b1;
    step();

    fill_basic();
    run_job("basic", 3, 0, 1'b0);
    check_basic_consts("basic");

    run_job("stall", 3, 1, 1'b0);
    check_basic_consts("stall");

    ma[0][0] = 2; ma[1][0] = 3; ma[2][0] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[0][2] = 7;
    run_job("k1", 1, 0, 1'b0);
    check_eq("k1_c00", mm.results[0 +: AW], 10);
    check_eq("k1_c22", mm.results[8*AW +: AW], 28);

    run_job("k0", 0, 0, 1'b0);

    for (int i = 0; i < NN; i++)
      for (int k = 0; k < KM; k++) begin
        ma[i][k] = 255;
        mb[k][i] = 255;
      end
    run_job("ovf", 2, 0, 1'b0);
`ifdef SYSTOLIC_SAT_EN
    check_eq("ovf_c11", mm.results[4*AW +: AW], 65535);
`else
    check_eq("ovf_c11", mm.results[4*AW +: AW], 64514);
`endif

    fill_basic();
    mm.k_len = KW'(3); mm.start = 1'b1;
    step();
    mm.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mm.in_valid = 1'b1; mm.a_col = a_beat(k); mm.b_row = b_beat(k);
      step();
    end
    mm.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_eq("midrst_ctrl", {mm.busy, mm.done, mm.in_ready}, 0);
    check_eq("midrst_res", mm.results, 0);
    step();
    step();
    @(negedge clk) rstn = 1'b1;
    step();
    run_job("post_rst", 3, 0, 1'b0);
    check_basic_consts("post_rst");

    fill_random();
    run_job("poke_start", 3, 0, 1'b1);

    fill_random();
    run_job("clamp", 20, 0, 1'b0);

    for (int t = 0; t < 5; t++) begin
      fill_random();
      run_job($sformatf("rnd%0d", t), $urandom_range(1, KM), 2, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
